// File: rtl/vram_diag_pkg.sv
// vram_diag_pkg: shared SPI command bytes, group size and readout FSM states
package vram_diag_pkg;
  localparam logic [7:0] READ_VRAM = 8'h88;
  localparam logic [7:0] PARITY_ERROR = 8'h22;
  localparam logic [7:0] PARITY_OK = 8'h00;
  localparam int GROUP_BYTES = 8;
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_DATA, S_PARITY, S_STATUS, S_COMMIT, S_FINISH, S_ABORT
  } state_t;
endpackage

// File: rtl/spi_master_byte.sv
// spi_master_byte: mode-0 SPI master exchanging one byte MSB first per load
module spi_master_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic       fpga_clk,
  input  logic       fpga_reset,
  input  logic       load,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic       ready,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso
);
  logic active_q, active_d, sclk_q, sclk_d, ready_q, ready_d, half;
  logic [7:0] tx_q, tx_d, rx_q, rx_d, cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] sync_q, sync_d;
  always_comb begin
    active_d = active_q;
    sclk_d = sclk_q;
    ready_d = 1'b0;
    tx_d = tx_q;
    rx_d = rx_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    sync_d = {sync_q[0], spi_miso};
    half = cnt_q == 8'(CLK_DIV - 1);
    if (!active_q) begin
      if (load) begin
        active_d = 1'b1;
        tx_d = tx_byte;
        cnt_d = '0;
        bit_d = '0;
        sclk_d = 1'b0;
      end
    end else begin
      cnt_d = half ? 8'd0 : cnt_q + 8'd1;
      if (half) begin
        sclk_d = !sclk_q;
        if (sclk_q) begin
          rx_d = {rx_q[6:0], sync_q[1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            active_d = 1'b0;
            ready_d = 1'b1;
          end else tx_d = {tx_q[6:0], 1'b0};
        end
      end
    end
  end
  always_ff @(posedge fpga_clk or posedge fpga_reset) begin
    if (fpga_reset) begin
      active_q <= 1'b0;
      sclk_q <= 1'b0;
      ready_q <= 1'b0;
      tx_q <= '0;
      rx_q <= '0;
      cnt_q <= '0;
      bit_q <= '0;
      sync_q <= '0;
    end else begin
      active_q <= active_d;
      sclk_q <= sclk_d;
      ready_q <= ready_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sync_q <= sync_d;
    end
  end
  assign rx_byte = rx_q;
  assign ready = ready_q;
  assign spi_clk = sclk_q;
  assign spi_mosi = tx_q[7];
endmodule

// File: rtl/vram_spi_reader.sv
// vram_spi_reader: reads VRAM over SPI in parity-checked 8-byte groups into a frame buffer
module vram_spi_reader
  import vram_diag_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int BYTE_GAP = 8,
  parameter int MAX_RETRIES = 3
) (
  input  logic        fpga_clk,
  input  logic        fpga_reset,
  input  logic        start,
  input  logic [10:0] vram_size,
  output logic        spi_clk,
  output logic        spi_select,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        wr_en,
  output logic [10:0] wr_address,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  retry_count
);
  state_t state_q, state_d;
  logic [GROUP_BYTES-1:0][7:0] buf_q, buf_d;
  logic [2:0] idx_q, idx_d;
  logic [10:0] rem_q, rem_d, base_q, base_d, wr_addr_q, wr_addr_d;
  logic [7:0] gap_q, gap_d, fails_q, fails_d, retry_q, retry_d, wr_data_q, wr_data_d;
  logic launched_q, launched_d, mis_q, mis_d, sel_q, sel_d, wr_en_q, wr_en_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic load, ready, last;
  logic [7:0] tx, rx, par;
  logic [3:0] gsz;
  spi_master_byte #(.CLK_DIV(CLK_DIV)) u_byte (
    .fpga_clk(fpga_clk), .fpga_reset(fpga_reset), .load(load), .tx_byte(tx),
    .rx_byte(rx), .ready(ready), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    idx_d = idx_q;
    rem_d = rem_q;
    base_d = base_q;
    gap_d = gap_q != 8'd0 ? gap_q - 8'd1 : gap_q;
    fails_d = fails_q;
    retry_d = retry_q;
    launched_d = launched_q;
    mis_d = mis_q;
    sel_d = sel_q;
    wr_en_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d = busy_q;
    done_d = 1'b0;
    error_d = error_q;
    par = '0;
    for (int k = 0; k < GROUP_BYTES; k++) par[k] = ^buf_q[k];
    gsz = rem_q >= 11'd8 ? 4'd8 : {1'b0, rem_q[2:0]};
    last = {1'b0, idx_q} == gsz - 4'd1;
    tx = state_q == S_CMD ? READ_VRAM : (state_q == S_STATUS && mis_q) ? PARITY_ERROR : PARITY_OK;
    load = 1'b0;
    if (state_q inside {S_CMD, S_DATA, S_PARITY, S_STATUS}) begin
      load = !launched_q && gap_q == 8'd0;
      if (load) launched_d = 1'b1;
      if (ready) begin
        launched_d = 1'b0;
        gap_d = 8'(BYTE_GAP);
      end
    end
    case (state_q)
      S_IDLE: if (start) begin
        error_d = 1'b0;
        retry_d = '0;
        if (vram_size == 11'd0) done_d = 1'b1;
        else begin
          state_d = S_CMD;
          busy_d = 1'b1;
          sel_d = 1'b0;
          rem_d = vram_size;
          base_d = '0;
          idx_d = '0;
          fails_d = '0;
          gap_d = '0;
          launched_d = 1'b0;
        end
      end
      S_CMD: if (ready) state_d = S_DATA;
      S_DATA: if (ready) begin
        buf_d[idx_q] = rx;
        idx_d = last ? 3'd0 : idx_q + 3'd1;
        if (last) state_d = rem_q >= 11'd8 ? S_PARITY : S_COMMIT;
      end
      S_PARITY: if (ready) begin
        mis_d = rx != par;
        state_d = S_STATUS;
      end
      S_STATUS: if (ready) begin
        if (!mis_q) state_d = S_COMMIT;
        else begin
          retry_d = retry_q + 8'(retry_q != 8'hFF);
          if (fails_q == 8'(MAX_RETRIES)) begin
            state_d = S_ABORT;
            sel_d = 1'b1;
            error_d = 1'b1;
          end else begin
            fails_d = fails_q + 8'd1;
            state_d = S_DATA;
          end
        end
      end
      S_COMMIT: begin
        wr_en_d = 1'b1;
        wr_addr_d = base_q + 11'(idx_q);
        wr_data_d = buf_q[idx_q];
        idx_d = last ? 3'd0 : idx_q + 3'd1;
        if (last) begin
          base_d = base_q + 11'(gsz);
          rem_d = rem_q - 11'(gsz);
          fails_d = '0;
          state_d = rem_q == 11'(gsz) ? S_FINISH : S_DATA;
          sel_d = rem_q == 11'(gsz);
        end
      end
      S_FINISH, S_ABORT: begin
        state_d = S_IDLE;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge fpga_clk or posedge fpga_reset) begin
    if (fpga_reset) begin
      state_q <= S_IDLE;
      buf_q <= '0;
      idx_q <= '0;
      rem_q <= '0;
      base_q <= '0;
      gap_q <= '0;
      fails_q <= '0;
      retry_q <= '0;
      launched_q <= 1'b0;
      mis_q <= 1'b0;
      sel_q <= 1'b1;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      idx_q <= idx_d;
      rem_q <= rem_d;
      base_q <= base_d;
      gap_q <= gap_d;
      fails_q <= fails_d;
      retry_q <= retry_d;
      launched_q <= launched_d;
      mis_q <= mis_d;
      sel_q <= sel_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q <= busy_d;
      done_q <= done_d;
      error_q <= error_d;
    end
  end
  assign spi_select = sel_q;
  assign wr_en = wr_en_q;
  assign wr_address = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = error_q;
  assign retry_count = retry_q;
endmodule

// File: tb/tb_vram_spi_reader.sv
// tb_vram_spi_reader: scoreboard bench with a behavioural parity-grouped SPI responder
module tb_vram_spi_reader;
  logic fpga_clk = 1'b0, fpga_reset = 1'b1, start = 1'b0;
  logic [10:0] vram_size = '0;
  logic spi_clk, spi_select, spi_mosi, wr_en, busy, done, error;
  wire logic spi_miso;
  logic [10:0] wr_address;
  logic [7:0] wr_data, retry_count;
  vram_spi_reader dut (
    .fpga_clk(fpga_clk), .fpga_reset(fpga_reset), .start(start), .vram_size(vram_size),
    .spi_clk(spi_clk), .spi_select(spi_select), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data), .busy(busy), .done(done),
    .error(error), .retry_count(retry_count)
  );
  always #5 fpga_clk = ~fpga_clk;
  int checks = 0, failures = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  logic [7:0] mem [0:2047];
  logic [7:0] sh = '0, msh = '0;
  logic [7:0] mosi_log [$];
  logic [18:0] exp_wr [$];
  int cfg_size = 0, cfg_db = 0, cfg_pb = 0;
  int ph = 4, bitn = 0, sidx = 0, sbase = 0, srem = 0, dcnt = 0, pcnt = 0, gsz;
  int n_sel_fall = 0, n_done = 0, n_wr = 0;
  logic psel = 1'b1, pclk = 1'b0;
  assign spi_miso = sh[7];
  function automatic logic [7:0] next_byte();
    logic [7:0] p;
    if (ph == 1) return mem[sbase + sidx] ^ ((sbase == 0 && dcnt > 0 && sidx == 3) ? 8'h04 : 8'h00);
    if (ph == 2) begin
      p = '0;
      for (int k = 0; k < 8; k++) p[k] = ^mem[sbase + k];
      return p ^ (pcnt > 0 ? 8'h01 : 8'h00);
    end
    return 8'h5A;
  endfunction
  always @(negedge fpga_clk) begin
    if (psel && !spi_select) begin
      n_sel_fall++;
      mosi_log.delete();
      ph = 0; bitn = 0; sidx = 0; sbase = 0; srem = cfg_size; dcnt = cfg_db; pcnt = cfg_pb;
      sh = 8'hC3;
    end
    if (!pclk && spi_clk) msh = {msh[6:0], spi_mosi};
    if (pclk && !spi_clk) begin
      sh = {sh[6:0], 1'b0};
      bitn++;
      if (bitn == 8) begin
        bitn = 0;
        mosi_log.push_back(msh);
        gsz = srem >= 8 ? 8 : srem;
        case (ph)
          0: begin ph = 1; sidx = 0; end
          1: begin sidx++; if (sidx == gsz) ph = gsz == 8 ? 2 : 4; end
          2: begin
            ph = 3;
            if (pcnt > 0) pcnt--;
            if (sbase == 0 && dcnt > 0) dcnt--;
          end
          3: begin
            sidx = 0;
            if (msh == 8'h22) ph = 1;
            else begin sbase += 8; srem -= 8; ph = srem > 0 ? 1 : 4; end
          end
          default: ;
        endcase
        sh = next_byte();
      end
    end
    psel = spi_select;
    pclk = spi_clk;
  end
  always @(negedge fpga_clk) begin
    if (done) n_done++;
    if (wr_en) begin
      n_wr++;
      if (exp_wr.size() == 0) check("wr_unexpected", 32'(wr_address), 32'hFFFF_FFFF);
      else begin
        logic [18:0] e;
        e = exp_wr.pop_front();
        check("wr_addr", 32'(wr_address), 32'(e[18:8]));
        check("wr_data", 32'(wr_data), 32'(e[7:0]));
      end
    end
  end
  task automatic chk_rst(input string p);
    check({p, "_sel"}, 32'(spi_select), 32'd1);
    check({p, "_sclk"}, 32'(spi_clk), 32'd0);
    check({p, "_mosi"}, 32'(spi_mosi), 32'd0);
    check({p, "_wren"}, 32'(wr_en), 32'd0);
    check({p, "_waddr"}, 32'(wr_address), 32'd0);
    check({p, "_wdata"}, 32'(wr_data), 32'd0);
    check({p, "_busy"}, 32'(busy), 32'd0);
    check({p, "_done"}, 32'(done), 32'd0);
    check({p, "_err"}, 32'(error), 32'd0);
    check({p, "_retry"}, 32'(retry_count), 32'd0);
  endtask
  task automatic do_start(input int sz);
    @(posedge fpga_clk); #1;
    vram_size = 11'(sz);
    start = 1'b1;
    @(posedge fpga_clk); #1;
    start = 1'b0;
  endtask
  task automatic run(input string tag, input int sz, input int db, input int pb, input bit good, input bit poke);
    int n;
    cfg_size = sz; cfg_db = db; cfg_pb = pb;
    if (good) for (int i = 0; i < sz; i++) exp_wr.push_back({11'(i), mem[i]});
    do_start(sz);
    n = 0;
    while (!done && n < 30000) begin
      if (poke && n == 200) begin
        vram_size = 11'd5; start = 1'b1;
        @(posedge fpga_clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_retry_mid"}, 32'(retry_count), 32'd0);
      end
      @(posedge fpga_clk); #1;
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_sel_end"}, 32'(spi_select), 32'd1);
    @(posedge fpga_clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_wr_missing"}, 32'(exp_wr.size()), 32'd0);
  endtask
  initial begin
    int w0, f0, d0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge fpga_clk);
    #1 chk_rst("reset");
    fpga_reset = 1'b0;
    run("clean16", 16, 0, 0, 1'b1, 1'b1);
    check("clean16_err", 32'(error), 32'd0);
    check("clean16_retry", 32'(retry_count), 32'd0);
    check("clean16_len", 32'(mosi_log.size()), 32'd21);
    for (int i = 0; i < mosi_log.size(); i++)
      check($sformatf("clean16_mosi%0d", i), 32'(mosi_log[i]), i == 0 ? 32'h88 : 32'h00);
    run("corrupt16", 16, 1, 0, 1'b1, 1'b0);
    check("corrupt16_err", 32'(error), 32'd0);
    check("corrupt16_retry", 32'(retry_count), 32'd1);
    check("corrupt16_len", 32'(mosi_log.size()), 32'd31);
    check("corrupt16_status0", 32'(mosi_log.size() > 10 ? mosi_log[10] : 8'hEE), 32'h22);
    check("corrupt16_status1", 32'(mosi_log.size() > 20 ? mosi_log[20] : 8'hEE), 32'h00);
    w0 = n_wr;
    run("abort8", 8, 0, 4, 1'b0, 1'b0);
    check("abort8_err", 32'(error), 32'd1);
    check("abort8_retry", 32'(retry_count), 32'd4);
    check("abort8_writes", 32'(n_wr - w0), 32'd0);
    check("abort8_len", 32'(mosi_log.size()), 32'd41);
    check("abort8_last", 32'(mosi_log.size() > 40 ? mosi_log[40] : 8'hEE), 32'h22);
    run("part11", 11, 0, 0, 1'b1, 1'b0);
    check("part11_err", 32'(error), 32'd0);
    check("part11_len", 32'(mosi_log.size()), 32'd14);
    check("part11_status", 32'(mosi_log.size() > 10 ? mosi_log[10] : 8'hEE), 32'h00);
    f0 = n_sel_fall; d0 = n_done;
    do_start(0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_sel", 32'(spi_select), 32'd1);
    repeat (20) @(posedge fpga_clk);
    #1 check("zero_sel_falls", 32'(n_sel_fall - f0), 32'd0);
    check("zero_done_count", 32'(n_done - d0), 32'd1);
    cfg_size = 16; cfg_db = 0; cfg_pb = 0;
    do_start(16);
    begin
      int n = 0;
      while (!spi_clk && n < 1000) begin @(posedge fpga_clk); #1; n++; end
    end
    check("midreset_sclk_high", 32'(spi_clk), 32'd1);
    #2 fpga_reset = 1'b1;
    #1 chk_rst("midreset");
    @(posedge fpga_clk); #1;
    fpga_reset = 1'b0;
    run("again16", 16, 0, 0, 1'b1, 1'b0);
    check("again16_err", 32'(error), 32'd0);
    check("again16_len", 32'(mosi_log.size()), 32'd21);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vram_spi_reader.md
VRAM_SPI_READER -- requirements
Module: vram_spi_reader

Interface
REQ-001 CLK_DIV, default 4: fpga_clk cycles per spi_clk half-period; minimum 2.
REQ-002 BYTE_GAP, default 8: fpga_clk cycles with spi_select low between consecutive bytes, so the responder can load its next tx byte.
REQ-003 MAX_RETRIES, default 3: parity-error retransmits permitted per 8-byte group.
REQ-004 fpga_clk  in  1  single clock; every flop uses it.
REQ-005 fpga_reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a VRAM readout; ignored while busy=1.
REQ-007 vram_size  in  11  byte count; sampled on the start cycle.
REQ-008 spi_clk  out  1  SPI clock, mode 0 (idle low).
REQ-009 spi_select  out  1  active-low chip select.
REQ-010 spi_mosi  out  1  master data out, MSB first.
REQ-011 spi_miso  in  1  slave data in; external synchronisation is not required.
REQ-012 wr_en, wr_address[10:0], wr_data[7:0]  out  frame-buffer write port; one byte per wr_en cycle.
REQ-013 busy  out  1  high from the start cycle until done.
REQ-014 done  out  1  one-cycle pulse at the end of a transfer.
REQ-015 error  out  1  sticky flag; set on abort and cleared by the next start.
REQ-016 retry_count  out  8  total retransmits in the current transfer; saturates at 255.

Function
REQ-017 Each SPI byte:
- 8 spi_clk periods; MOSI is driven before each rising edge; MISO is sampled on each rising edge.
- Sampling uses a 2-flop synchroniser; spi_clk returns low after bit 0.
REQ-018 Transfer sequence:
- spi_select goes low CLK_DIV cycles before the first edge.
- Byte 0 is command 0x88; its MISO content is discarded.
REQ-019 Each full group is 9 exchanges with MOSI=0x00:
- 8 data bytes, buffered locally, then 1 parity byte.
- Bit k of the parity byte is the XOR of all bits of data byte k.
REQ-020 After the parity byte, one status exchange:
- MOSI=0x00 if every bit matches the locally computed parity.
- MOSI=0x22 on any mismatch; the responder then resends the same 8 bytes.
REQ-021 Commit on a good group: 8 consecutive wr_en cycles at wr_address base..base+7, then base advances by 8.
REQ-022 No write reaches the frame buffer for a group that failed parity.
REQ-023 Final partial group (vram_size mod 8 = r, r ≠ 0): r data bytes, no parity exchange, no status exchange, committed unchecked.
REQ-024 After the last commit: spi_select high, then done pulses.
REQ-025 vram_size=0: done pulses on the cycle after start; spi_select stays high and no SPI activity occurs.
REQ-026 Failure limit: a group failing MAX_RETRIES+1 consecutive times causes an abort.
- spi_select goes high after the current byte and error=1.
- done pulses; nothing further is written.
REQ-027 retry_count increments once per 0x22 sent; it clears on start.
REQ-028 FSM states:
- IDLE→CMD on start with vram_size≠0.
- CMD→DATA.
- DATA→PARITY after the 8th byte, or DATA→COMMIT after byte r of the final partial group.
- PARITY→STATUS.
- STATUS→COMMIT on match; STATUS→DATA on retry; STATUS→ABORT at the limit.
- COMMIT→DATA if bytes remain, otherwise COMMIT→FINISH.
- FINISH→IDLE; ABORT→IDLE.
REQ-029 start asserted while busy has no effect on any output.

Reset
REQ-030 Reset values: spi_select=1, spi_clk=0, spi_mosi=0, wr_en=0, wr_address=0, wr_data=0, busy=0, done=0, error=0, retry_count=0; FSM in IDLE.
REQ-031 Reset mid-transfer takes effect asynchronously: spi_select rises immediately and no further wr_en is issued.

Structure
REQ-032 Shared package vram_diag_pkg holds: READ_VRAM=8'h88, PARITY_ERROR=8'h22, PARITY_OK=8'h00, GROUP_BYTES=8, and the FSM state enum.
REQ-033 One sub-module, spi_master_byte, shifts one byte.
- Handshake: load/tx_byte in; rx_byte/ready out; CLK_DIV parameter.
- The top level owns grouping, parity, retry and commit.

Verification
REQ-034 vram_size=16 with a clean responder → MOSI sequence 88,00×9,00,00×9,00; 16 writes to addresses 0..15; done=1, error=0, retry_count=0.
REQ-035 vram_size=16 with one corrupted data bit in group 0 → status byte 0x22 and group 0 resent; addresses 0..7 written exactly once with good data; retry_count=1.
REQ-036 vram_size=8 with parity corrupted 4 times → abort: error=1, retry_count=4, no wr_en, spi_select=1.
REQ-037 vram_size=11 → one checked group plus 3 unchecked bytes; addresses 8..10 written; exactly one parity exchange.
REQ-038 vram_size=0 → done on the next cycle, spi_select never low; reset asserted mid-byte → all REQ-030 values at once, and the next start runs cleanly.
